// File: rtl/dac_controller_if.sv
// Signal bundle between the pid core, the DAC serial pins and dac_controller.
// The master drives the sample bus; the slave (controller) drives the SPI pins and status.
interface dac_controller_if #(
  parameter int W_DATA = 16,
  parameter int N_CHAN = 8
);
  logic signed [W_DATA-1:0] data_in;
  logic [N_CHAN-1:0]        data_valid_in;
  logic                     n_cs_out;
  logic                     sclk_out;
  logic                     sdi_out;
  logic                     busy_out;
  logic [N_CHAN-1:0]        wr_done_out;

  modport master (
    output data_in, data_valid_in,
    input  n_cs_out, sclk_out, sdi_out, busy_out, wr_done_out
  );

  modport slave (
    input  data_in, data_valid_in,
    output n_cs_out, sclk_out, sdi_out, busy_out, wr_done_out
  );
endinterface

// File: rtl/dac_controller.sv
// Round-robin SPI transmitter feeding pid results to an 8-channel DAC8568.
// One pending slot per channel (newest value wins); an init frame goes out after every reset.
module dac_controller #(
  parameter int          W_DATA     = 16,
  parameter int          N_CHAN     = 8,
  parameter int          W_FRAME    = 32,
  parameter int          T_CSH      = 2,
  parameter logic [3:0]  CMD_WR     = 4'h3,
  parameter logic [31:0] INIT_FRAME = 32'h08000001
) (
  input logic             clk_in,
  input logic             reset_in,
  dac_controller_if.slave bus
);

  localparam int W_CNT = $clog2(2 * W_FRAME);
  localparam int W_PTR = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int W_CSH = (T_CSH > 1) ? $clog2(T_CSH) : 1;
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(2 * W_FRAME - 1);
  localparam logic [W_CSH-1:0] CSH_LAST = W_CSH'(T_CSH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CSH
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [N_CHAN-1:0]  pend;
  logic [N_CHAN-1:0]  pend_next;
  logic [W_DATA-1:0]  data_reg [N_CHAN];
  logic [W_PTR-1:0]   rr_ptr;
  logic               init_pend;
  logic [W_PTR-1:0]   chan;
  logic               chan_is_init;
  logic [W_FRAME-1:0] shift_reg;
  logic [W_FRAME-1:0] data_frame;
  logic [W_CNT-1:0]   cnt;
  logic [W_CSH-1:0]   csh_cnt;
  logic [N_CHAN-1:0]  req;
  logic               req_any;
  logic [W_PTR-1:0]   pick;
  logic [N_CHAN-1:0]  wr_done;

  // Valids arriving in the idle cycle count as requests so a fresh sample starts without an extra cycle.
  always_comb begin
    int idx;
    idx     = 0;
    req     = pend | bus.data_valid_in;
    req_any = |req;
    pick    = rr_ptr;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % N_CHAN;
      if (req[idx]) pick = W_PTR'(idx);
    end
  end

  always_comb begin
    pend_next = pend | bus.data_valid_in;
    if (state == ST_LOAD && !chan_is_init) pend_next[chan] = bus.data_valid_in[chan];
  end

  assign data_frame = W_FRAME'({4'b0000, CMD_WR, 4'(chan), data_reg[chan], 4'b0000});

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (init_pend || req_any) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_LAST) state_next = ST_CSH;
      ST_CSH:   if (csh_cnt == CSH_LAST) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pend         <= '0;
      rr_ptr       <= '0;
      init_pend    <= 1'b1;
      chan         <= '0;
      chan_is_init <= 1'b0;
      shift_reg    <= '0;
      cnt          <= '0;
      csh_cnt      <= '0;
    end else begin
      pend <= pend_next;
      case (state)
        ST_IDLE: begin
          if (init_pend) begin
            chan_is_init <= 1'b1;
          end else if (req_any) begin
            chan_is_init <= 1'b0;
            chan         <= pick;
          end
        end
        ST_LOAD: begin
          cnt <= '0;
          if (chan_is_init) begin
            shift_reg <= INIT_FRAME[W_FRAME-1:0];
            init_pend <= 1'b0;
          end else begin
            shift_reg <= data_frame;
            rr_ptr    <= (int'(chan) == N_CHAN - 1) ? '0 : chan + 1'b1;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt[0]) shift_reg <= {shift_reg[W_FRAME-2:0], 1'b0};
          if (cnt == CNT_LAST) csh_cnt <= '0;
        end
        ST_CSH: begin
          csh_cnt <= csh_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Offset binary is the two's-complement value with its sign bit flipped.
  always_ff @(posedge clk_in) begin
    for (int k = 0; k < N_CHAN; k++) begin
      if (!reset_in && bus.data_valid_in[k])
        data_reg[k] <= {~bus.data_in[W_DATA-1], bus.data_in[W_DATA-2:0]};
    end
  end

  always_comb begin
    wr_done = '0;
    if (state == ST_SHIFT && cnt == CNT_LAST && !chan_is_init) wr_done[chan] = 1'b1;
  end

  assign bus.n_cs_out    = (state != ST_SHIFT);
  assign bus.sclk_out    = (state == ST_SHIFT) ? ~cnt[0] : 1'b1;
  assign bus.sdi_out     = (state == ST_SHIFT) ? shift_reg[W_FRAME-1] : 1'b0;
  assign bus.busy_out    = (state != ST_IDLE);
  assign bus.wr_done_out = wr_done;

endmodule
